rf_writeback_unit: RTL and testbench
====================================

// Module: rf_writeback_unit
// PURPOSE
//  Write side of the 32x32 register file: merges single-cycle ALU results and
//  variable-latency load results into the one register-file write port
//  (rd / rd_data / reg_write). ALU has fixed priority. Loads are buffered in an
//  in-order FIFO with valid/ready backpressure. A pending-write bitmask is
//  exported for hazard detection. Sits between EX/MEM and the register file.
// PARAMETERS
//  XLEN        32  data width
//  REG_ADDR_W  5   register index width (32 registers)
//  DEPTH       4   load FIFO entries; power of 2, >= 2
// PORTS
//  clk        in   1           system clock, all state on posedge
//  rst        in   1           synchronous, active-high reset
//  alu_valid  in   1           ALU result present this cycle (cannot stall)
//  alu_rd     in   REG_ADDR_W  ALU destination register
//  alu_data   in   XLEN        ALU result
//  mem_valid  in   1           load result offered
//  mem_rd     in   REG_ADDR_W  load destination register
//  mem_data   in   XLEN        load data
//  mem_ready  out  1           load result accepted when mem_valid & mem_ready
//  rd         out  REG_ADDR_W  register-file write index (registered)
//  rd_data    out  XLEN        register-file write data (registered)
//  reg_write  out  1           register-file write enable (registered)
//  pending    out  32          bit i = write to x(i) queued or on output regs
// BEHAVIOUR
//  Reset (rst=1 at posedge): reg_write=0, rd=0, rd_data=0, FIFO empty;
//   mem_ready=0 while rst=1. Mid-operation reset discards all queued loads.
//  mem_ready = ~rst & ~fifo_full (full = DEPTH entries). Pops in the same cycle
//   are not credited.
//  Accept = mem_valid & mem_ready. Accepted loads with mem_rd=0 are dropped
//   (never queued, never written). ALU results with alu_rd=0 are ignored.
//  Output register selection each posedge (priority order):
//   1. alu_valid & alu_rd!=0 -> {alu_rd, alu_data}, reg_write=1
//   2. FIFO non-empty        -> pop head, reg_write=1
//   3. accept & FIFO empty & mem_rd!=0 -> bypass load directly, reg_write=1
//   4. otherwise             -> reg_write=0; rd, rd_data hold last value
//  Enqueue: accepted load with mem_rd!=0 that did not bypass (case 1 or 2 taken)
//   is pushed. Push and pop in the same cycle are legal; count unchanged.
//  Latency: ALU N -> reg_write at N+1. Load to empty FIFO with no ALU: N -> N+1.
//   Otherwise loads leave in arrival order on the first ALU-idle cycles.
//  Loads are never reordered among themselves. ALU may overtake queued loads;
//   ordering of same-rd ALU vs load writes is the issue stage's job (pending).
//  pending: combinational OR of one-hot(rd) over all valid FIFO entries and the
//   output register when reg_write=1. Bit 0 is always 0.
//  FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH; full/empty use a
//   separate count (0..DEPTH).
// TESTING
//  Reset: rst=1 for 2 cycles -> reg_write=0, rd=0, rd_data=0, mem_ready=0,
//   pending=0; then mem_ready=1.
//  ALU only: alu_rd=5, data=0x1234 at N -> N+1 rd=5, rd_data=0x1234,
//   reg_write=1, pending[5]=1. alu_rd=0 -> reg_write=0.
//  Collision: ALU rd=3 and load rd=7 (0xAA) same cycle -> N+1 writes x3;
//   N+2 writes x7=0xAA. pending[7]=1 from N+1 through N+2.
//  Backpressure: ALU valid every cycle, 5 loads offered (DEPTH=4) -> 4 accepted,
//   mem_ready=0 when full. Drop ALU -> loads written in order, one per cycle.
//   mem_ready returns 1 after the first pop.
//  Wrap: 10 interleaved push/pop loads through the FIFO -> data/rd written in
//   exact arrival order, no loss or duplication.
//  Reset mid-op: 3 loads queued, rst=1 one cycle -> FIFO empty, pending=0;
//   none of the queued writes appear afterwards.

Source files
------------

// File: rtl/rf_writeback_unit_if.sv
// Writeback bundle: ALU and load result inputs, register-file write port and hazard mask.
interface rf_writeback_unit_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    localparam int NREG = 1 << REG_ADDR_W;

    logic                  alu_valid;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_data;
    logic                  mem_valid;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic [XLEN-1:0]       mem_data;
    logic                  mem_ready;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       rd_data;
    logic                  reg_write;
    logic [NREG-1:0]       pending;

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        input  mem_ready, rd, rd_data, reg_write, pending
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        output mem_ready, rd, rd_data, reg_write, pending
    );
endinterface

// File: rtl/rf_writeback_unit.sv
// Merges ALU results (fixed priority) and in-order load results onto the single register-file write port.
// Latency: one cycle from ALU result or bypassed load to reg_write; queued loads leave on ALU-idle cycles.
// Backpressure: mem_ready drops while the load FIFO is full or in reset; same-cycle pops are not credited.
module rf_writeback_unit #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 4
) (
    input  logic                clk,
    input  logic                rst,
    rf_writeback_unit_if.slave  wb
);
    localparam int NREG  = 1 << REG_ADDR_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    wb_entry_t             fifo_mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    logic                  out_write;
    logic [REG_ADDR_W-1:0] out_rd;
    logic [XLEN-1:0]       out_data;

    logic fifo_full, fifo_empty;
    logic mem_ready_int, accept, load_live, alu_live;
    logic pop, bypass, push;

    assign fifo_full     = (count == CNT_W'(DEPTH));
    assign fifo_empty    = (count == '0);
    assign mem_ready_int = ~rst & ~fifo_full;
    assign accept        = wb.mem_valid & mem_ready_int;
    assign load_live     = accept & (wb.mem_rd != '0);
    assign alu_live      = wb.alu_valid & (wb.alu_rd != '0);
    assign pop           = ~alu_live & ~fifo_empty;
    assign bypass        = ~alu_live & fifo_empty & load_live;
    assign push          = load_live & ~bypass;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_write <= 1'b0;
            out_rd    <= '0;
            out_data  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            if (alu_live) begin
                out_write <= 1'b1;
                out_rd    <= wb.alu_rd;
                out_data  <= wb.alu_data;
            end else if (pop) begin
                out_write <= 1'b1;
                out_rd    <= fifo_mem[rd_ptr].rd;
                out_data  <= fifo_mem[rd_ptr].data;
            end else if (bypass) begin
                out_write <= 1'b1;
                out_rd    <= wb.mem_rd;
                out_data  <= wb.mem_data;
            end else begin
                out_write <= 1'b0;
            end
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage needs no reset: validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr].rd   <= wb.mem_rd;
            fifo_mem[wr_ptr].data <= wb.mem_data;
        end
    end

    logic [NREG-1:0]  pending_vec;
    logic [PTR_W-1:0] offs;

    always_comb begin
        pending_vec = '0;
        offs        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = PTR_W'(i) - rd_ptr;
            if (CNT_W'(offs) < count)
                pending_vec[fifo_mem[i].rd] = 1'b1;
        end
        if (out_write)
            pending_vec[out_rd] = 1'b1;
        pending_vec[0] = 1'b0;
    end

    assign wb.mem_ready = mem_ready_int;
    assign wb.reg_write = out_write;
    assign wb.rd        = out_rd;
    assign wb.rd_data   = out_data;
    assign wb.pending   = pending_vec;
endmodule

// File: tb/tb_rf_writeback_unit.sv
// Drives directed and random ALU/load traffic and compares against a queue-based writeback model.
module tb_rf_writeback_unit;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rf_writeback_unit_if #(.XLEN(32), .REG_ADDR_W(5)) wb ();

    rf_writeback_unit #(.XLEN(32), .REG_ADDR_W(5), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: queued loads as {rd, data}, plus the expected write-port registers.
    logic [36:0] q[$];
    logic        exp_rw;
    logic [4:0]  exp_rd;
    logic [31:0] exp_dat;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_pending();
        logic [31:0] p = '0;
        foreach (q[i]) p[q[i][36:32]] = 1'b1;
        if (exp_rw) p[exp_rd] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    // One clock: drive inputs at negedge, check ready/pending, advance model, check write port.
    task automatic cycle(input logic r, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        logic exp_ready, acc, was_empty, bypassed;
        rst          = r;
        wb.alu_valid = av;
        wb.alu_rd    = ard;
        wb.alu_data  = ad;
        wb.mem_valid = mv;
        wb.mem_rd    = mrd;
        wb.mem_data  = md;
        #1;
        exp_ready = !r && (q.size() < DEPTH);
        chk("mem_ready", 64'(wb.mem_ready), 64'(exp_ready));
        chk("pending", 64'(wb.pending), 64'(model_pending()));
        acc = mv && exp_ready;
        if (r) begin
            q.delete();
            exp_rw = 1'b0; exp_rd = '0; exp_dat = '0;
        end else begin
            was_empty = (q.size() == 0);
            bypassed  = 1'b0;
            if (av && ard != 0) begin
                exp_rw = 1'b1; exp_rd = ard; exp_dat = ad;
            end else if (!was_empty) begin
                exp_rw = 1'b1; {exp_rd, exp_dat} = q.pop_front();
            end else if (acc && mrd != 0) begin
                exp_rw = 1'b1; exp_rd = mrd; exp_dat = md; bypassed = 1'b1;
            end else begin
                exp_rw = 1'b0;
            end
            if (acc && mrd != 0 && !bypassed) q.push_back({mrd, md});
        end
        @(posedge clk);
        @(negedge clk);
        chk("reg_write", 64'(wb.reg_write), 64'(exp_rw));
        chk("rd", 64'(wb.rd), 64'(exp_rd));
        chk("rd_data", 64'(wb.rd_data), 64'(exp_dat));
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        wb.alu_valid = 1'b0; wb.alu_rd = '0; wb.alu_data = '0;
        wb.mem_valid = 1'b0; wb.mem_rd = '0; wb.mem_data = '0;
        exp_rw = 1'b0; exp_rd = '0; exp_dat = '0;
        @(posedge clk);
        @(negedge clk);

        // Reset held two cycles, then ready rises.
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("rst_pending", 64'(wb.pending), 64'd0);
        idle();
        chk("post_rst_ready", 64'(wb.mem_ready), 64'd1);

        // ALU only, then x0 target ignored.
        cycle(1'b0, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
        chk("alu_rd5", 64'(wb.rd), 64'd5);
        chk("alu_data", 64'(wb.rd_data), 64'h1234);
        chk("alu_pend5", 64'(wb.pending[5]), 64'd1);
        cycle(1'b0, 1'b1, 5'd0, 32'hdead, 1'b0, 5'd0, 32'd0);
        chk("alu_x0_rw", 64'(wb.reg_write), 64'd0);

        // Collision: ALU wins, load follows next cycle.
        cycle(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'hAA);
        chk("col_rd3", 64'(wb.rd), 64'd3);
        chk("col_pend7_n1", 64'(wb.pending[7]), 64'd1);
        idle();
        chk("col_rd7", 64'(wb.rd), 64'd7);
        chk("col_data", 64'(wb.rd_data), 64'hAA);
        chk("col_pend7_n2", 64'(wb.pending[7]), 64'd1);
        idle();

        // Backpressure: ALU busy, five loads offered, four fit.
        for (int i = 0; i < 5; i++)
            cycle(1'b0, 1'b1, 5'(20 + i), 32'(i), 1'b1, 5'(10 + i), 32'h100 + 32'(i));
        chk("bp_full_ready", 64'(wb.mem_ready), 64'd0);
        idle();
        chk("bp_first_rd", 64'(wb.rd), 64'd10);
        chk("bp_ready_back", 64'(wb.mem_ready), 64'd1);
        repeat (4) idle();

        // Wrap: ten loads with alternating ALU traffic.
        for (int i = 0; i < 10; i++)
            cycle(1'b0, 1'(i % 2), 5'd9, 32'(i), 1'b1, 5'(1 + i), 32'h200 + 32'(i));
        repeat (6) idle();

        // Reset mid-operation discards queued loads.
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b1, 5'd2, 32'(i), 1'b1, 5'(12 + i), 32'h300 + 32'(i));
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("midrst_pending", 64'(wb.pending), 64'd0);
        repeat (3) idle();

        // Random traffic with phases of heavy and light ALU load.
        for (int i = 0; i < 600; i++) begin
            int alu_pct = ((i / 50) % 2) ? 85 : 25;
            logic [4:0] ard = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            logic [4:0] mrd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            cycle($urandom_range(0, 99) == 0,
                  $urandom_range(0, 99) < alu_pct, ard, $urandom,
                  $urandom_range(0, 99) < 60, mrd, $urandom);
        end
        repeat (8) idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
